// File: rtl/sharp_filter_npx.sv
// Multi-lane 3x3 Laplacian sharpening filter: two-stage valid/ready pipeline
// with frame-latched configuration and per-frame saturation statistics.
module sharp_filter_npx #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIX_PER_CLK = 1,
  parameter int COEF_WIDTH  = 8,
  parameter int COEF_FRAC   = 6,
  parameter int STAT_WIDTH  = 24
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COEF_WIDTH-1:0]               cfg_coef,
  input  logic [1:0]                          cfg_mode,
  input  logic                                in3x3_val,
  output logic                                in3x3_rdy,
  input  logic [PIX_PER_CLK*9*DATA_WIDTH-1:0] in3x3_data,
  input  logic                                in3x3_sof,
  input  logic                                in3x3_eof,
  input  logic                                in3x3_sol,
  input  logic                                in3x3_eol,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [PIX_PER_CLK*DATA_WIDTH-1:0]   out_data,
  output logic                                out_sof,
  output logic                                out_eof,
  output logic                                out_sol,
  output logic                                out_eol,
  output logic [STAT_WIDTH-1:0]               stat_sat_cnt,
  output logic                                stat_val
);

  localparam int WW = 9 * DATA_WIDTH;
  localparam int LW = DATA_WIDTH + 5;
  localparam int PW = LW + COEF_WIDTH + 1;
  localparam int SW = PW + 1;
  localparam int AW = STAT_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;
  localparam logic signed [SW-1:0] SUM_MAX = SW'((2 ** DATA_WIDTH) - 1);

  // Marker bit positions inside the 4-bit marker bundle
  localparam int MK_SOF = 3;
  localparam int MK_EOF = 2;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_SHARPEN = 2'd1,
    MODE_LAP     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  logic                            in_xfer;
  logic                            s2_load;
  logic                            out_xfer;
  mode_e                           eff_mode;
  logic [COEF_WIDTH-1:0]           eff_coef;

  mode_e                           shd_mode_q;
  logic [COEF_WIDTH-1:0]           shd_coef_q;

  logic                            s1_val_q;
  mode_e                           s1_mode_q;
  logic [COEF_WIDTH-1:0]           s1_coef_q;
  logic [3:0]                      s1_mark_q;
  logic [PIX_PER_CLK*LW-1:0]       s1_lap_q, s1_lap_d;
  logic [PIX_PER_CLK*DATA_WIDTH-1:0] s1_ctr_q, s1_ctr_d;

  logic                            out_val_q;
  logic [PIX_PER_CLK*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]                      out_mark_q;
  logic [PIX_PER_CLK-1:0]          out_sat_q, out_sat_d;

  logic [STAT_WIDTH-1:0]           acc_q;
  logic [STAT_WIDTH-1:0]           stat_cnt_q;
  logic                            stat_val_q;
  logic [AW-1:0]                   beat_cnt_d;
  logic [AW-1:0]                   acc_sum;
  logic [STAT_WIDTH-1:0]           acc_clip;

  assign in_xfer   = in3x3_val & in3x3_rdy;
  assign s2_load   = s1_val_q & (~out_val_q | out_rdy);
  assign in3x3_rdy = ~s1_val_q | s2_load;
  assign out_xfer  = out_val_q & out_rdy;

  // The sof beat itself already uses the configuration it carries
  assign eff_mode = in3x3_sof ? mode_e'(cfg_mode) : shd_mode_q;
  assign eff_coef = in3x3_sof ? cfg_coef : shd_coef_q;

  for (genvar gi = 0; gi < PIX_PER_CLK; gi++) begin : g_lane
    logic [LW-1:0]          nsum;
    logic [DATA_WIDTH-1:0]  ctr_in;
    logic signed [LW-1:0]   lap;
    logic [DATA_WIDTH-1:0]  ctr;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic signed [SW-1:0]   sum;
    logic [LW-1:0]          mag;
    logic [DATA_WIDTH-1:0]  res;
    logic                   sat;

    always_comb begin
      nsum = '0;
      for (int j = 0; j < 9; j++) begin
        if (j != 4) begin
          nsum = nsum + LW'(in3x3_data[gi*WW + j*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end

    assign ctr_in = in3x3_data[gi*WW + 4*DATA_WIDTH +: DATA_WIDTH];
    assign s1_ctr_d[gi*DATA_WIDTH +: DATA_WIDTH] = ctr_in;
    assign s1_lap_d[gi*LW +: LW] = (LW'(ctr_in) << 3) - nsum;

    assign lap     = $signed(s1_lap_q[gi*LW +: LW]);
    assign ctr     = s1_ctr_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign prod    = PW'(lap) * PW'($signed({1'b0, s1_coef_q}));
    assign shifted = prod >>> COEF_FRAC;
    assign sum     = SW'(shifted) + $signed({{(SW-DATA_WIDTH){1'b0}}, ctr});
    assign mag     = lap[LW-1] ? $unsigned(-lap) : $unsigned(lap);

    always_comb begin
      res = ctr;
      sat = 1'b0;
      case (s1_mode_q)
        MODE_SHARPEN: begin
          if (sum[SW-1]) begin
            res = '0;
            sat = 1'b1;
          end else if (sum > SUM_MAX) begin
            res = PIX_MAX;
            sat = 1'b1;
          end else begin
            res = sum[DATA_WIDTH-1:0];
          end
        end
        MODE_LAP: res = (mag > LW'(PIX_MAX)) ? PIX_MAX : mag[DATA_WIDTH-1:0];
        default:  res = ctr;
      endcase
    end

    assign out_data_d[gi*DATA_WIDTH +: DATA_WIDTH] = res;
    assign out_sat_d[gi] = sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_mode_q <= MODE_BYPASS;
      shd_coef_q <= '0;
      s1_val_q   <= 1'b0;
      s1_mode_q  <= MODE_BYPASS;
      s1_coef_q  <= '0;
      s1_mark_q  <= '0;
      s1_lap_q   <= '0;
      s1_ctr_q   <= '0;
    end else begin
      if (in_xfer) begin
        s1_val_q  <= 1'b1;
        s1_mode_q <= eff_mode;
        s1_coef_q <= eff_coef;
        s1_mark_q <= {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol};
        s1_lap_q  <= s1_lap_d;
        s1_ctr_q  <= s1_ctr_d;
        if (in3x3_sof) begin
          shd_mode_q <= mode_e'(cfg_mode);
          shd_coef_q <= cfg_coef;
        end
      end else if (s2_load) begin
        s1_val_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_mark_q <= '0;
      out_sat_q  <= '0;
    end else if (s2_load) begin
      out_val_q  <= 1'b1;
      out_data_q <= out_data_d;
      out_mark_q <= s1_mark_q;
      out_sat_q  <= out_sat_d;
    end else if (out_xfer) begin
      out_val_q <= 1'b0;
    end
  end

  always_comb begin
    beat_cnt_d = '0;
    for (int k = 0; k < PIX_PER_CLK; k++) begin
      beat_cnt_d = beat_cnt_d + AW'(out_sat_q[k]);
    end
    acc_sum  = AW'(acc_q) + beat_cnt_d;
    acc_clip = acc_sum[STAT_WIDTH] ? '1 : acc_sum[STAT_WIDTH-1:0];
  end

  // Clamps are counted when the beat leaves the block, not when computed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      stat_cnt_q <= '0;
      stat_val_q <= 1'b0;
    end else begin
      stat_val_q <= 1'b0;
      if (out_xfer) begin
        if (out_mark_q[MK_EOF]) begin
          stat_cnt_q <= acc_clip;
          stat_val_q <= 1'b1;
          acc_q      <= '0;
        end else if (out_mark_q[MK_SOF]) begin
          acc_q <= beat_cnt_d[STAT_WIDTH-1:0];
        end else begin
          acc_q <= acc_clip;
        end
      end
    end
  end

  assign out_val      = out_val_q;
  assign out_data     = out_data_q;
  assign {out_sof, out_eof, out_sol, out_eol} = out_mark_q;
  assign stat_sat_cnt = stat_cnt_q;
  assign stat_val     = stat_val_q;

endmodule

// File: tb/tb_sharp_filter_npx.sv
// Directed bench for sharp_filter_npx with four lanes per beat.
module tb_sharp_filter_npx;

  localparam int DW = 8;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      cfg_coef = '0;
  logic [1:0]      cfg_mode = '0;
  logic            in3x3_val = 1'b0;
  logic            in3x3_rdy;
  logic [NP*9*DW-1:0] in3x3_data = '0;
  logic            in3x3_sof = 1'b0, in3x3_eof = 1'b0, in3x3_sol = 1'b0, in3x3_eol = 1'b0;
  logic            out_val;
  logic            out_rdy = 1'b1;
  logic [NP*DW-1:0] out_data;
  logic            out_sof, out_eof, out_sol, out_eol;
  logic [23:0]     stat_sat_cnt;
  logic            stat_val;

  int checks = 0;
  int errors = 0;

  logic [35:0] cap_q[$];
  logic [23:0] stat_q[$];

  always #5 clk = ~clk;

  sharp_filter_npx #(
    .DATA_WIDTH(DW), .PIX_PER_CLK(NP), .COEF_WIDTH(8), .COEF_FRAC(6), .STAT_WIDTH(24)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_coef(cfg_coef), .cfg_mode(cfg_mode),
    .in3x3_val(in3x3_val), .in3x3_rdy(in3x3_rdy), .in3x3_data(in3x3_data),
    .in3x3_sof(in3x3_sof), .in3x3_eof(in3x3_eof), .in3x3_sol(in3x3_sol), .in3x3_eol(in3x3_eol),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .out_sol(out_sol), .out_eol(out_eol),
    .stat_sat_cnt(stat_sat_cnt), .stat_val(stat_val)
  );

  always @(negedge clk) begin
    if (rst_n && out_val && out_rdy) cap_q.push_back({out_data, out_sof, out_eof, out_sol, out_eol});
    if (rst_n && stat_val) stat_q.push_back(stat_sat_cnt);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  // Window with centre c, tap 0 = t0, remaining neighbours n
  function automatic logic [71:0] win(input int c, input int n, input int t0);
    logic [71:0] w;
    for (int j = 0; j < 9; j++) w[j*8 +: 8] = (j == 4) ? 8'(c) : (j == 0) ? 8'(t0) : 8'(n);
    return w;
  endfunction

  function automatic logic [71:0] flat(input int v);
    return win(v, v, v);
  endfunction

  function automatic logic [35:0] pick(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 'x;
  endfunction

  task automatic put(input logic [NP*9*DW-1:0] d, input logic [3:0] mk);
    bit ok;
    int tries;
    in3x3_val  = 1'b1;
    in3x3_data = d;
    {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} = mk;
    tries = 0;
    do begin
      @(negedge clk);
      ok = in3x3_rdy;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 50);
    in3x3_val = 1'b0;
    {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} = 4'b0000;
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 60 && cap_q.size() < n; i++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_val, out_data, out_sof, out_eof, out_sol, out_eol, stat_val, stat_sat_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got val=%b data=%h mk=%b sv=%b sc=%0d expected all zero",
               out_val, out_data, {out_sof, out_eof, out_sol, out_eol}, stat_val, stat_sat_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in3x3_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b expected 1", in3x3_rdy);
    end
    // Non-sof beat must use the reset shadow config (bypass)
    cap_q.delete();
    cfg_mode = 2'd1;
    cfg_coef = 8'd64;
    put({flat(100), flat(100), flat(100), win(200, 100, 100)}, 4'b0000);
    wait_cap(1);
    checks++;
    if (pick(0) !== {8'd100, 8'd100, 8'd100, 8'd200, 4'b0000} || cap_q.size() != 1) begin
      errors++;
      $display("FAIL reset_shadow got %h (n=%0d) expected %h", pick(0), cap_q.size(),
               {8'd100, 8'd100, 8'd100, 8'd200, 4'b0000});
    end
  endtask

  task automatic test_flat();
    cap_q.delete();
    stat_q.delete();
    cfg_mode = 2'd1;
    cfg_coef = 8'd64;
    put({4{flat(100)}}, 4'b1111);
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0) begin
      errors++;
      $display("FAIL flat_latency1 got out_val=%b expected 0", out_val);
    end
    @(negedge clk);
    checks++;
    if ({out_val, out_data, out_sof, out_eof, out_sol, out_eol} !== {1'b1, 32'h64646464, 4'b1111}) begin
      errors++;
      $display("FAIL flat_latency2 got val=%b data=%h mk=%b expected val=1 data=64646464 mk=1111",
               out_val, out_data, {out_sof, out_eof, out_sol, out_eol});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 24'd0) begin
      errors++;
      $display("FAIL flat_stat got n=%0d cnt=%0d expected n=1 cnt=0", stat_q.size(),
               (stat_q.size() > 0) ? stat_q[0] : 24'hffffff);
    end
  endtask

  task automatic test_clamp();
    cap_q.delete();
    stat_q.delete();
    put({flat(100), flat(100), flat(100), win(200, 100, 100)}, 4'b1010);
    put({flat(100), flat(100), flat(100), win(50, 100, 100)}, 4'b0101);
    wait_cap(2);
    checks++;
    if (pick(0) !== {8'd100, 8'd100, 8'd100, 8'd255, 4'b1010}) begin
      errors++;
      $display("FAIL clamp_high got %h expected %h", pick(0), {8'd100, 8'd100, 8'd100, 8'd255, 4'b1010});
    end
    checks++;
    if (pick(1) !== {8'd100, 8'd100, 8'd100, 8'd0, 4'b0101}) begin
      errors++;
      $display("FAIL clamp_low got %h expected %h", pick(1), {8'd100, 8'd100, 8'd100, 8'd0, 4'b0101});
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 24'd2) begin
      errors++;
      $display("FAIL clamp_stat got n=%0d cnt=%0d expected n=1 cnt=2", stat_q.size(),
               (stat_q.size() > 0) ? stat_q[0] : 24'hffffff);
    end
  endtask

  task automatic test_lap_bypass();
    logic [NP*9*DW-1:0] b;
    cap_q.delete();
    stat_q.delete();
    b = {flat(100), win(255, 0, 0), win(0, 255, 255), win(10, 20, 20)};
    cfg_mode = 2'd2;
    put(b, 4'b1111);
    cfg_mode = 2'd0;
    put(b, 4'b1111);
    cfg_mode = 2'd3;
    put(b, 4'b1111);
    wait_cap(3);
    checks++;
    if (pick(0) !== {8'd0, 8'd255, 8'd255, 8'd80, 4'b1111}) begin
      errors++;
      $display("FAIL lap_mode got %h expected %h", pick(0), {8'd0, 8'd255, 8'd255, 8'd80, 4'b1111});
    end
    checks++;
    if (pick(1) !== {8'd100, 8'd255, 8'd0, 8'd10, 4'b1111}) begin
      errors++;
      $display("FAIL bypass_mode0 got %h expected %h", pick(1), {8'd100, 8'd255, 8'd0, 8'd10, 4'b1111});
    end
    checks++;
    if (pick(2) !== {8'd100, 8'd255, 8'd0, 8'd10, 4'b1111}) begin
      errors++;
      $display("FAIL bypass_mode3 got %h expected %h", pick(2), {8'd100, 8'd255, 8'd0, 8'd10, 4'b1111});
    end
    checks++;
    if (stat_q.size() != 3 || (stat_q[0] | stat_q[1] | stat_q[2]) !== 24'd0) begin
      errors++;
      $display("FAIL lap_stat got n=%0d expected n=3 all zero", stat_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  mk [6];
    logic [36:0] held;
    int idx, hold_bad;
    bit rdy_drop, stall, ok;
    logic [35:0] exp;
    mk = '{4'b1010, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0101};
    cap_q.delete();
    cfg_mode = 2'd1;
    cfg_coef = 8'd64;
    idx = 0; hold_bad = 0; rdy_drop = 0; stall = 0; held = '0;
    for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
      in3x3_val  = 1'b1;
      in3x3_data = {4{flat(10 * (idx + 1))}};
      {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} = mk[idx];
      out_rdy = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (!in3x3_rdy) rdy_drop = 1;
      if (stall && {out_val, out_data, out_sof, out_eof, out_sol, out_eol} !== held) hold_bad++;
      stall = out_val && !out_rdy;
      held  = {out_val, out_data, out_sof, out_eof, out_sol, out_eol};
      ok = in3x3_rdy;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    in3x3_val = 1'b0;
    {in3x3_sof, in3x3_eof, in3x3_sol, in3x3_eol} = 4'b0000;
    out_rdy = 1'b1;
    wait_cap(6);
    checks++;
    if (rdy_drop !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy_drop got %b expected 1", rdy_drop);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d changes expected 0", hold_bad);
    end
    checks++;
    if (cap_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count got %0d expected 6", cap_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      exp = {{4{8'(10 * (i + 1))}}, mk[i]};
      checks++;
      if (pick(i) !== exp) begin
        errors++;
        $display("FAIL bp_beat%0d got %h expected %h", i, pick(i), exp);
      end
    end
  endtask

  task automatic test_cfg_shadow();
    logic [NP*9*DW-1:0] b;
    logic [35:0] exp;
    logic [3:0]  mk [4];
    logic [7:0]  v  [4];
    mk = '{4'b1010, 4'b0000, 4'b0101, 4'b1111};
    v  = '{8'd172, 8'd172, 8'd172, 8'd100};
    cap_q.delete();
    b = {flat(100), flat(100), flat(100), win(100, 91, 91)};
    cfg_mode = 2'd1;
    cfg_coef = 8'd64;
    put(b, mk[0]);
    cfg_coef = 8'd0;
    cfg_mode = 2'd0;
    put(b, mk[1]);
    put(b, mk[2]);
    cfg_mode = 2'd1;
    put(b, mk[3]);
    wait_cap(4);
    for (int i = 0; i < 4; i++) begin
      exp = {8'd100, 8'd100, 8'd100, v[i], mk[i]};
      checks++;
      if (pick(i) !== exp) begin
        errors++;
        $display("FAIL shadow_beat%0d got %h expected %h", i, pick(i), exp);
      end
    end
  endtask

  task automatic test_boundaries();
    cap_q.delete();
    stat_q.delete();
    cfg_mode = 2'd1;
    cfg_coef = 8'd255;
    put({flat(255), flat(0), win(100, 100, 99), win(100, 100, 101)}, 4'b1111);
    wait_cap(1);
    checks++;
    if (pick(0) !== {8'd255, 8'd0, 8'd103, 8'd96, 4'b1111}) begin
      errors++;
      $display("FAIL bound_floor got %h expected %h", pick(0), {8'd255, 8'd0, 8'd103, 8'd96, 4'b1111});
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 24'd0) begin
      errors++;
      $display("FAIL bound_stat got n=%0d cnt=%0d expected n=1 cnt=0", stat_q.size(),
               (stat_q.size() > 0) ? stat_q[0] : 24'hffffff);
    end
  endtask

  task automatic test_multilane_reset();
    logic [NP*9*DW-1:0] b;
    logic [35:0] exp;
    b = {win(250, 200, 200), win(30, 40, 40), win(50, 40, 40), win(100, 91, 91)};
    exp = {8'd255, 8'd0, 8'd130, 8'd172, 4'b1111};
    cap_q.delete();
    stat_q.delete();
    cfg_mode = 2'd1;
    cfg_coef = 8'd64;
    put(b, 4'b1111);
    wait_cap(1);
    checks++;
    if (pick(0) !== exp) begin
      errors++;
      $display("FAIL lanes_data got %h expected %h", pick(0), exp);
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 24'd2) begin
      errors++;
      $display("FAIL lanes_stat got n=%0d cnt=%0d expected n=1 cnt=2", stat_q.size(),
               (stat_q.size() > 0) ? stat_q[0] : 24'hffffff);
    end
    // Two beats in flight, then reset
    cap_q.delete();
    stat_q.delete();
    put(b, 4'b1010);
    put(b, 4'b0000);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_val, out_data, out_sof, out_eof, out_sol, out_eol, stat_val, stat_sat_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got val=%b data=%h sc=%0d expected all zero",
               out_val, out_data, stat_sat_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (cap_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_spurious got beats=%0d stats=%0d expected 0 0", cap_q.size(), stat_q.size());
    end
    put(b, 4'b1111);
    wait_cap(1);
    checks++;
    if (pick(0) !== exp || cap_q.size() != 1) begin
      errors++;
      $display("FAIL postreset_data got %h (n=%0d) expected %h", pick(0), cap_q.size(), exp);
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 24'd2) begin
      errors++;
      $display("FAIL postreset_stat got n=%0d cnt=%0d expected n=1 cnt=2", stat_q.size(),
               (stat_q.size() > 0) ? stat_q[0] : 24'hffffff);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_clamp();
    test_lap_bypass();
    test_back_to_back();
    test_cfg_shadow();
    test_boundaries();
    test_multilane_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
